issue_scheduler: RTL

- Consumer side of dependency tracking for the ESM instruction buffer.
- Holds up to bs in-flight instructions and records, at allocation, which live slots each new entry has a RAW dependency on.
- Issues, one per cycle, the lowest-index instruction whose dependencies have all completed.
- Releases a slot on completion and wakes up the instructions that were waiting on it.

---
 rtl/issue_scheduler_if.sv | 44 ++++
 rtl/issue_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// issue_scheduler_if
// Bundles the three channels of the issue scheduler:
//   alloc    : alloc_valid/alloc_ready handshake, rd/rs1/rs2 of the new
//              instruction, and alloc_index (the slot it will occupy)
//   issue    : issue_valid/issue_ready handshake, issue_index, issue_rd
//   complete : complete_valid, complete_index
//   count    : number of occupied slots
// The slave modport is the scheduler side; the master modport is the
// side that feeds instructions and consumes issues.
// ---------------------------------------------------------------------------
interface issue_scheduler_if #(
    parameter int bs     = 32,
    parameter int regnum = 16
);
    localparam int IW = $clog2(bs);
    localparam int RW = $clog2(regnum);

    logic          alloc_valid;
    logic          alloc_ready;
    logic [RW-1:0] alloc_rd;
    logic [RW-1:0] alloc_rs1;
    logic [RW-1:0] alloc_rs2;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_index;
    logic [RW-1:0] issue_rd;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic [IW:0]   count;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_rs1, alloc_rs2,
        input  issue_ready, complete_valid, complete_index,
        output alloc_ready, alloc_index, issue_valid, issue_index, issue_rd, count
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_rs1, alloc_rs2,
        output issue_ready, complete_valid, complete_index,
        input  alloc_ready, alloc_index, issue_valid, issue_index, issue_rd, count
    );
endinterface

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
// Tracks up to bs in-flight instructions. At allocation each new entry
// records a wait bit for every live slot that produces one of its sources
// (RAW). One instruction per cycle is issued: the lowest-index slot that is
// live, not yet issued and has no outstanding wait bits. A completion frees
// the slot and clears its wait bit in every other entry.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   sif  - slave side of issue_scheduler_if (alloc / issue / complete / count)
// ---------------------------------------------------------------------------
module issue_scheduler #(
    parameter int bs     = 32,
    parameter int regnum = 16
) (
    input  logic            clk,
    input  logic            rst,
    issue_scheduler_if.slave sif
);
    localparam int IW = $clog2(bs);
    localparam int RW = $clog2(regnum);

    logic [bs-1:0] live_q,   live_d;
    logic [bs-1:0] issued_q, issued_d;
    logic [RW-1:0] rd_q     [bs];
    logic [RW-1:0] rd_d     [bs];
    logic [bs-1:0] wait_q   [bs];
    logic [bs-1:0] wait_d   [bs];
    logic [IW:0]   count_q,  count_d;

    logic [bs-1:0] issuable;
    logic [bs-1:0] new_wait;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] iss_idx;
    logic          iss_vld;
    logic          alloc_fire;
    logic          iss_fire;
    logic          cpl_fire;

    // Free-slot and issue selection depend only on registered state, so
    // neither output has a combinational path from the inputs.
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        issuable = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            issuable[i] = live_q[i] & ~issued_q[i] & ~(|wait_q[i]);
            if (!live_q[i]) free_idx = IW'(i);
            if (issuable[i]) iss_idx = IW'(i);
        end
        iss_vld = |issuable;
    end

    assign sif.alloc_ready = ~(&live_q);
    assign sif.alloc_index = free_idx;
    assign sif.issue_valid = iss_vld;
    assign sif.issue_index = iss_idx;
    assign sif.issue_rd    = iss_vld ? rd_q[iss_idx] : '0;
    assign sif.count       = count_q;

    assign alloc_fire = sif.alloc_valid & sif.alloc_ready;
    assign iss_fire   = iss_vld & sif.issue_ready;
    // Completions for slots that are free or not yet issued are dropped.
    assign cpl_fire   = sif.complete_valid & live_q[sif.complete_index]
                        & issued_q[sif.complete_index];

    always_comb begin
        live_d   = live_q;
        issued_d = issued_q;
        rd_d     = rd_q;
        wait_d   = wait_q;
        count_d  = count_q;
        new_wait = '0;

        // A producer completing this very cycle is already done, so no wait
        // bit is recorded for it. x0 producers never create a dependency.
        // The target slot is free, so it can never match itself.
        for (int j = 0; j < bs; j++) begin
            new_wait[j] = live_q[j] && (rd_q[j] != '0)
                          && ((rd_q[j] == sif.alloc_rs1) || (rd_q[j] == sif.alloc_rs2))
                          && !(cpl_fire && (sif.complete_index == IW'(j)));
        end

        if (cpl_fire) begin
            live_d[sif.complete_index]   = 1'b0;
            issued_d[sif.complete_index] = 1'b0;
            for (int i = 0; i < bs; i++) begin
                wait_d[i][sif.complete_index] = 1'b0;
            end
        end

        if (iss_fire) begin
            issued_d[iss_idx] = 1'b1;
        end

        if (alloc_fire) begin
            live_d[free_idx]   = 1'b1;
            issued_d[free_idx] = 1'b0;
            rd_d[free_idx]     = sif.alloc_rd;
            wait_d[free_idx]   = new_wait;
        end

        case ({alloc_fire, cpl_fire})
            2'b10:   count_d = count_q + (IW+1)'(1);
            2'b01:   count_d = count_q - (IW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= '0;
            issued_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < bs; i++) begin
                rd_q[i]   <= '0;
                wait_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            issued_q <= issued_d;
            count_q  <= count_d;
            for (int i = 0; i < bs; i++) begin
                rd_q[i]   <= rd_d[i];
                wait_q[i] <= wait_d[i];
            end
        end
    end
endmodule
